// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: assembles big-endian words, writes imem, then releases the CPU.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module mips_prog_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  input  logic              i_load_req,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_run,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_words_loaded,
  output logic              o_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic                r_cpu_run;
  logic                r_busy;
  logic [ADDR_W:0]     r_words;
  logic [ADDR_W:0]     r_count;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;

  logic                w_accept;
  logic [8:0]          w_cnt9;
  logic                w_cnt_clamp;
  logic [ADDR_W:0]     w_count;
  logic                w_last;

  assign w_accept    = i_in_valid & r_in_ready;
  assign w_cnt9      = {1'b0, i_in_data};
  // A count of zero or one larger than the memory loads the whole memory.
  assign w_cnt_clamp = (w_cnt9 == 9'd0) || (w_cnt9 > 9'(DEPTH));
  assign w_count     = w_cnt_clamp ? DEPTH_W : w_cnt9[ADDR_W:0];
  assign w_last      = (r_words + (ADDR_W+1)'(1)) == r_count;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_err;
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_run    <= 1'b0;
      r_busy       <= 1'b0;
      r_words      <= '0;
      r_count      <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_count <= w_count;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], i_in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ i_in_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_words[ADDR_W-1:0];
              r_imem_wdata <= {r_shift, i_in_data};
              r_in_ready   <= 1'b0;
              r_state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_words <= r_words + (ADDR_W+1)'(1);
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            r_in_ready <= 1'b1;
            r_state    <= S_CHK;
`else
            r_cpu_run  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
`endif
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (i_in_data == r_csum) begin
              r_cpu_run <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        S_ERROR: begin
          if (i_load_req) begin
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_words    <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_state    <= S_IDLE;
          end
        end
`endif
        S_DONE: begin
          if (i_load_req) begin
            r_cpu_run  <= 1'b0;
            r_in_ready <= 1'b1;
            r_words    <= '0;
            r_byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_cpu_run  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_cpu_run      = r_cpu_run;
  assign o_busy         = r_busy;
  assign o_words_loaded = r_words;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: expected imem writes are queued by the stimulus
// and popped by a monitor on every write strobe.
module tb_mips_prog_loader;

  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              busy;
  logic [ADDR_W:0]   words_loaded;
  logic              err;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  int   gap = 0;
  logic [7:0] model_x;

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .i_load_req(load_req), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata), .o_cpu_run(cpu_run),
    .o_busy(busy), .o_words_loaded(words_loaded), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        chk("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected none", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {27'd0, imem_addr}, {27'd0, e.addr});
          chk("write_data", imem_wdata, e.data);
        end
        last_we_cyc = cyc;
      end
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_count(input logic [7:0] b);
    model_x = 8'h00;
    send_byte(b);
  endtask

  task automatic send_data(input logic [7:0] b);
    model_x ^= b;
    send_byte(b);
  endtask

  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    send_byte(model_x);
`endif
  endtask

  task automatic wait_run(input string name, input int exp_words);
    int t = 0;
    while (!cpu_run && t < 200) begin
      @(negedge clk);
      t++;
    end
`ifdef LOADER_CHECKSUM_EN
    chk({name, "_run_latency"}, 32'(t), 32'd0);
`else
    chk({name, "_run_after_write"}, 32'(cyc), 32'(last_we_cyc + 1));
`endif
    chk({name, "_cpu_run"}, {31'd0, cpu_run}, 32'd1);
    chk({name, "_words"}, 32'(words_loaded), 32'(exp_words));
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic reload();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("reload_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("reload_words", 32'(words_loaded), 32'd0);
    chk("reload_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  logic [7:0] prog2 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};

  initial begin
    fork
      monitor();
    join_none
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; load_req = 1'b0; model_x = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Test 1: reset in the middle of a word
    send_count(8'h02); send_data(8'h20); send_data(8'h08);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready_low", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);

    // Test 2: two-word program, back-to-back bytes
    push(0, 32'h2008_0005); push(1, 32'h0109_5020);
    send_count(8'h02);
    for (int i = 0; i < 8; i++) send_data(prog2[i]);
    finish_load();
    wait_run("t2", 2);
    reload();

    // Test 3: same program with gaps, plus a load_req that must be ignored mid-load
    gap = 1;
    push(0, 32'h2008_0005); push(1, 32'h0109_5020);
    send_count(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_data(prog2[i]);
      if (i == 2) begin
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("ignored_load_req_busy", {31'd0, busy}, 32'd1);
      end
    end
    finish_load();
    gap = 0;
    wait_run("t3", 2);
    reload();

    // Test 4: count 0x00 and 0xFF both load all 32 words
    for (int w = 0; w < 32; w++)
      push(w, {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    send_count(8'h00);
    for (int k = 0; k < 128; k++) send_data(8'(k));
    finish_load();
    wait_run("t4_zero", 32);
    reload();
    for (int w = 0; w < 32; w++)
      push(w, {8'(4*w) ^ 8'hA5, 8'(4*w+1) ^ 8'hA5, 8'(4*w+2) ^ 8'hA5, 8'(4*w+3) ^ 8'hA5});
    send_count(8'hFF);
    for (int k = 0; k < 128; k++) send_data(8'(k) ^ 8'hA5);
    finish_load();
    wait_run("t4_ff", 32);

    // Test 5: load_req coincident with a byte in DONE, then a one-word reload
    in_valid = 1'b1; in_data = 8'h01; load_req = 1'b1;
    chk("done_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; load_req = 1'b0;
    chk("t5_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("t5_words", 32'(words_loaded), 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    push(0, 32'hDEAD_BEEF);
    send_count(8'h01);
    send_data(8'hDE); send_data(8'hAD); send_data(8'hBE); send_data(8'hEF);
    finish_load();
    wait_run("t5", 1);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: wrong checksum lands in ERROR; load_req clears it
    reload();
    push(0, 32'h2008_0005); push(1, 32'h0109_5020);
    send_count(8'h02);
    for (int i = 0; i < 8; i++) send_data(prog2[i]);
    send_byte(8'h00);
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd0);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("t6_err_cleared", {31'd0, err}, 32'd0);
    chk("t6_ready_idle", {31'd0, in_ready}, 32'd1);
`else
    chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
